timer_core_param: RTL

- Parametrised successor to the two-mode minute timer core.
- Generates a 1 s tick from the system clock and runs the time in one of three modes:
  - count-down to zero
  - count-up stopwatch to a preset
  - auto-reload count-down that repeats indefinitely
- A single active-low start/stop button controls it. Outputs are binary seconds/minutes for the display decoder, plus status LEDs and pulses.

---
 rtl/timer_core_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/timer_core_param.sv
`timescale 1ns/1ps
// timer_core_param: 1 s prescaled minute/second timer with count-down, count-up and
// auto-reload count-down modes. Define TIMER_LAP_EN to add the lap capture input/outputs.
module timer_core_param #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int MIN_W       = 8,
    parameter int SEL_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_stop_n,
    input  logic [1:0]       mode_sel,
    input  logic [SEL_W-1:0] time_sel,
`ifdef TIMER_LAP_EN
    input  logic             lap_n,
    output logic [7:0]       lap_sec,
    output logic [MIN_W-1:0] lap_min,
`endif
    output logic [7:0]       sec_out,
    output logic [MIN_W-1:0] min_out,
    output logic             running,
    output logic             stop_led,
    output logic             done_pulse
);

    localparam int            PW     = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_SEC - 1);

    // Largest minute value is 2^SEL_W, which has to fit in the minutes counter.
    if (CLK_PER_SEC < 2) begin : g_bad_cps
        $error("timer_core_param: CLK_PER_SEC must be at least 2");
    end
    if (SEL_W >= MIN_W) begin : g_bad_width
        $error("timer_core_param: SEL_W must be smaller than MIN_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic             r_up;
    logic             r_reload;
    logic [SEL_W-1:0] r_tsel;
    logic [7:0]       r_sec;
    logic [MIN_W-1:0] r_min;
    logic             r_running;
    logic             r_stop_led;
    logic             r_done;

    logic             r_ss_s1, r_ss_s2, r_ss_prev;
    logic             w_press;
    logic             w_tick;
    logic             w_expire;
    logic [7:0]       w_nxt_sec;
    logic [MIN_W-1:0] w_nxt_min;
    logic [MIN_W-1:0] w_live_min;
    logic [MIN_W-1:0] w_latch_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_prev <= 1'b1;
        end else begin
            r_ss_s1   <= start_stop_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_prev <= r_ss_s2;
        end
    end

    assign w_press     = !r_ss_s2 && r_ss_prev;
    assign w_tick      = (r_presc == P_LAST);
    assign w_live_min  = (mode_sel == 2'b01) ? '0 : MIN_W'(time_sel) + MIN_W'(1);
    assign w_latch_min = MIN_W'(r_tsel) + MIN_W'(1);

    // Value after the next tick; a count-down already at 00:00 reloads (auto-reload only).
    always_comb begin
        w_nxt_sec = r_sec;
        w_nxt_min = r_min;
        w_expire  = 1'b0;
        if (r_up) begin
            if (r_sec < 8'd59) begin
                w_nxt_sec = r_sec + 8'd1;
            end else begin
                w_nxt_sec = 8'd0;
                w_nxt_min = r_min + MIN_W'(1);
            end
            w_expire = (w_nxt_sec == 8'd0) && (w_nxt_min == w_latch_min);
        end else begin
            if (r_sec != 8'd0) begin
                w_nxt_sec = r_sec - 8'd1;
            end else if (r_min != '0) begin
                w_nxt_sec = 8'd59;
                w_nxt_min = r_min - MIN_W'(1);
            end else begin
                w_nxt_sec = 8'd0;
                w_nxt_min = w_latch_min;
            end
            w_expire = (w_nxt_sec == 8'd0) && (w_nxt_min == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_up       <= 1'b0;
            r_reload   <= 1'b0;
            r_tsel     <= '0;
            r_sec      <= 8'd0;
            r_min      <= '0;
            r_running  <= 1'b0;
            r_stop_led <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sec <= 8'd0;
                    r_min <= w_live_min;
                    if (w_press) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_up      <= (mode_sel == 2'b01);
                        r_reload  <= (mode_sel == 2'b10);
                        r_tsel    <= time_sel;
                        r_presc   <= '0;
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        r_sec  <= w_nxt_sec;
                        r_min  <= w_nxt_min;
                        r_done <= w_expire;
                    end
                    // Expiry outranks a simultaneous press unless the mode reloads.
                    if (w_tick && w_expire && !r_reload) begin
                        r_state    <= S_DONE;
                        r_running  <= 1'b0;
                        r_stop_led <= 1'b1;
                    end else if (w_press) begin
                        r_state    <= S_PAUSE;
                        r_running  <= 1'b0;
                        r_stop_led <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (w_press) begin
                        r_state    <= S_RUN;
                        r_running  <= 1'b1;
                        r_stop_led <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (w_press) begin
                        r_state    <= S_RUN;
                        r_running  <= 1'b1;
                        r_stop_led <= 1'b0;
                        r_presc    <= '0;
                        r_sec      <= 8'd0;
                        r_min      <= r_up ? '0 : w_latch_min;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sec_out    = r_sec;
    assign min_out    = r_min;
    assign running    = r_running;
    assign stop_led   = r_stop_led;
    assign done_pulse = r_done;

`ifdef TIMER_LAP_EN
    logic             r_lap_s1, r_lap_s2, r_lap_prev;
    logic             w_lap;
    logic [7:0]       r_lap_sec;
    logic [MIN_W-1:0] r_lap_min;

    assign w_lap = !r_lap_s2 && r_lap_prev;

    // Captures the value as it stands after this cycle, so a coincident tick is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_s1   <= 1'b1;
            r_lap_s2   <= 1'b1;
            r_lap_prev <= 1'b1;
            r_lap_sec  <= 8'd0;
            r_lap_min  <= '0;
        end else begin
            r_lap_s1   <= lap_n;
            r_lap_s2   <= r_lap_s1;
            r_lap_prev <= r_lap_s2;
            if (w_lap && r_state == S_RUN) begin
                r_lap_sec <= w_tick ? w_nxt_sec : r_sec;
                r_lap_min <= w_tick ? w_nxt_min : r_min;
            end
        end
    end

    assign lap_sec = r_lap_sec;
    assign lap_min = r_lap_min;
`endif

endmodule
